// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared constants, types and state encoding for the image pixel path
package img_pkg;

  localparam int IMG_W     = 640;
  localparam int IMG_H     = 480;
  localparam int ADDR_W    = 19;
  localparam int PIX_W     = 8;
  localparam int WORD_W    = 16;
  localparam int FRAME_PIX = IMG_W * IMG_H;

  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } stream_state_t;

endpackage

// File: rtl/image_pixel_streamer_pix_pos_counter.sv
// rtl/image_pixel_streamer_pix_pos_counter.sv - raster x/y counters with sof/eol/eof decode
module pix_pos_counter #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  parameter int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          valid,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          sof,
  output logic          eol,
  output logic          eof
);

  logic last_x;
  logic last_y;

  assign last_x = (x == XW'(IMG_W - 1));
  assign last_y = (y == YW'(IMG_H - 1));

  // Advance one pixel per enable; x wraps at end of line, y wraps at end of frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (last_x) begin
        x <= '0;
        y <= last_y ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Framing flags only mean something while a pixel is being offered.
  assign sof = valid & (x == '0) & (y == '0);
  assign eol = valid & last_x;
  assign eof = valid & last_x & last_y;

endmodule

// File: rtl/image_pixel_streamer.sv
// rtl/image_pixel_streamer.sv - walks the image ROM two pixels per word and emits a framed 8-bit stream
module image_pixel_streamer
  import img_pkg::stream_state_t, img_pkg::word_t,
         img_pkg::IDLE, img_pkg::LOAD, img_pkg::STREAM, img_pkg::DONE;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy,
  output logic              done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  stream_state_t state;
  word_t         word_buf;
  logic          sel;
  logic          hs;
  logic          cnt_clr;
  logic          cnt_en;
  logic [XW-1:0] unused_x;
  logic [YW-1:0] unused_y;

  assign hs = pix_valid & pix_ready;

  // Counters restart whenever a frame is launched or cancelled; abort beats the handshake.
  assign cnt_clr = abort | ((state == IDLE) & start);
  assign cnt_en  = hs & ~abort;

  pix_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .XW    (XW),
    .YW    (YW)
  ) u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .valid (pix_valid),
    .x     (unused_x),
    .y     (unused_y),
    .sof   (pix_sof),
    .eol   (pix_eol),
    .eof   (pix_eof)
  );

  // The high byte is the earlier pixel in raster order.
  assign pix_data = sel ? word_buf[7:0] : word_buf[15:8];

  // Frame sequencer: rom_addr always points at the next word to fetch, so the
  // second-pixel handshake can refill the buffer without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rom_addr  <= '0;
      word_buf  <= '0;
      sel       <= 1'b0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      state     <= IDLE;
      rom_addr  <= '0;
      sel       <= 1'b0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            state    <= LOAD;
            rom_addr <= '0;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          word_buf  <= rom_data;
          sel       <= 1'b0;
          rom_addr  <= rom_addr + ADDR_W'(2);
          pix_valid <= 1'b1;
          state     <= STREAM;
        end
        STREAM: begin
          if (hs) begin
            if (pix_eof) begin
              state     <= DONE;
              pix_valid <= 1'b0;
              done      <= 1'b1;
            end else if (!sel) begin
              sel <= 1'b1;
            end else begin
              word_buf <= rom_data;
              rom_addr <= rom_addr + ADDR_W'(2);
              sel      <= 1'b0;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_pixel_streamer.sv
// tb/tb_image_pixel_streamer.sv - self-checking bench for image_pixel_streamer on a 4x2 frame
module tb_image_pixel_streamer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 19;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic [7:0]    pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_sof;
  logic          pix_eol;
  logic          pix_eof;
  logic          busy;
  logic          done;

  int tests  = 0;
  int errors = 0;

  image_pixel_streamer #(
    .IMG_W  (W),
    .IMG_H  (H),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .pix_eof   (pix_eof),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: byte[n] = n[7:0]
  always_comb rom_data = {rom_addr[7:0], rom_addr[7:0] + 8'd1};

  typedef struct {
    logic       start;
    logic       abort;
    logic       ready;
    logic [5:0] flags;   // {valid, sof, eol, eof, busy, done}
    logic [7:0] data;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outflags();
    return {pix_valid, pix_sof, pix_eol, pix_eof, busy, done};
  endfunction

  // mode 0: ready always high; mode 1: ready 1,0,1,0...; start re-pulsed at restart_at
  task automatic run_frame(input int mode, input int restart_at, input string tag);
    int         k = 0;
    int         dones = 0;
    bit         prev_stall = 0;
    bit         seen_valid = 0;
    bit         eof_done = 0;
    logic [10:0] held;
    logic [2:0]  expf;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      start     = (cyc == 0) || (cyc == restart_at);
      abort     = 1'b0;
      pix_ready = (mode == 1) ? ((cyc % 2) == 0) : 1'b1;
      @(negedge clk);
      if (prev_stall)
        check({tag, "_hold"}, {21'd0, pix_data, pix_sof, pix_eol, pix_eof}, {21'd0, held});
      if (seen_valid && !eof_done)
        check({tag, "_nogap"}, pix_valid, 1);
      if (pix_valid) seen_valid = 1;
      if (pix_valid && pix_ready) begin
        expf = {k == 0, (k % W) == W - 1, k == W * H - 1};
        check({tag, "_data"}, pix_data, k[7:0]);
        check({tag, "_flags"}, {pix_sof, pix_eol, pix_eof}, expf);
        if (pix_eof) eof_done = 1;
        k++;
      end
      prev_stall = pix_valid && !pix_ready;
      held = {pix_data, pix_sof, pix_eol, pix_eof};
      if (done) dones++;
    end
    start = 1'b0;
    check({tag, "_handshakes"}, k, W * H);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_idle_after"}, {busy, pix_valid}, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    pix_ready = 1'b0;

    // basic 4x2 frame, ready tied high: start in cycle 0
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 6'b000000, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 6'b000010, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 6'b110010, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 6'b100010, 8'h01};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 6'b100010, 8'h02};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 6'b101010, 8'h03};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 6'b100010, 8'h04};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 6'b100010, 8'h05};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 6'b100010, 8'h06};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 6'b101110, 8'h07};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 6'b000011, 8'h00};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 6'b000000, 8'h00};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", outflags(), 6'b000000);
    check("reset_addr", rom_addr, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      start     = vecs[i].start;
      abort     = vecs[i].abort;
      pix_ready = vecs[i].ready;
      @(negedge clk);
      check($sformatf("vec%0d_flags", i), outflags(), vecs[i].flags);
      if (vecs[i].flags[5])
        check($sformatf("vec%0d_data", i), pix_data, vecs[i].data);
    end
    start = 1'b0;

    run_frame(1, -1, "stall");
    run_frame(0, 5, "restart");

    // start and abort together while idle: abort wins
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle", {busy, pix_valid}, 0);

    // abort right after the 3rd handshake
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      start     = (c == 0);
      abort     = (c == 5);
      pix_ready = 1'b1;
      @(negedge clk);
      if (c == 5) check("abort_cycle_data", {pix_valid, pix_data}, {1'b1, 8'h03});
    end
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_after", {pix_valid, busy, done}, 0);
    check("abort_addr", rom_addr, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_done", {done, busy}, 0);
    end
    run_frame(0, -1, "post_abort");

    // asynchronous reset mid-frame
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      start     = (c == 0);
      pix_ready = 1'b1;
    end
    start = 1'b0;
    #2;
    check("pre_reset_valid", {pix_valid, busy}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("async_reset", {pix_valid, busy, done}, 0);
    check("async_reset_addr", rom_addr, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("reset_stays_idle", {pix_valid, busy, done}, 0);
    end
    run_frame(0, -1, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/image_pixel_streamer.md
Name: image_pixel_streamer

Overview:
- Downstream consumer of the combinational image ROM (8-bit pixels, raster order, 640x480).
- On a start pulse it walks the frame, reading 16-bit words (two adjacent pixels) from one ROM read port.
- It re-emits the frame as an 8-bit pixel stream with valid/ready handshake and sof/eol/eof framing flags for the processing stages that follow.

Parameters:
- IMG_W, 640, pixels per line; must be even.
- IMG_H, 480, lines per frame.
- ADDR_W, 19, ROM byte-address width; IMG_W*IMG_H must be <= 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle frame request; ignored unless idle.
- abort  in  1  cancel the current frame.
- rom_addr  out  ADDR_W  byte address to the ROM read port.
- rom_data  in  16  combinational ROM word: [15:8]=byte at rom_addr, [7:0]=byte at rom_addr+1.
- pix_data  out  8  current pixel.
- pix_valid  out  1  pix_data and the flags are valid.
- pix_ready  in  1  consumer accepts the pixel this cycle.
- pix_sof  out  1  first pixel of frame (x=0, y=0).
- pix_eol  out  1  last pixel of a line (x=IMG_W-1).
- pix_eof  out  1  last pixel of frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the final pixel is accepted.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE, rom_addr=0, word buffer=0, sel=0, x=0, y=0, pix_valid=0, busy=0, done=0; sof/eol/eof=0.
- States: IDLE, LOAD, STREAM, DONE.
- IDLE: busy=0. start=1 -> LOAD, with rom_addr=0.
- LOAD: busy=1. At the next edge, capture rom_data into the buffer, sel<=0, rom_addr<=rom_addr+2 -> STREAM.
- STREAM: pix_valid=1. pix_data = sel ? buf[7:0] : buf[15:8].
- Handshake is pix_valid & pix_ready.
  - Handshake with sel=0: sel<=1.
  - Handshake with sel=1 and not eof: capture rom_data, rom_addr<=rom_addr+2, sel<=0. This sustains 1 pixel/cycle with no bubble.
  - Handshake with eof: -> DONE.
- DONE: pix_valid=0, busy=1, done=1 for exactly one cycle -> IDLE.
- Latency: start high in cycle 0 -> pix_valid high from cycle 2. With pix_ready tied high, the frame occupies exactly IMG_W*IMG_H consecutive valid cycles, and done is high in the cycle after the eof handshake.
- Stall: pix_ready=0 holds pix_data, the flags, rom_addr and the counters stable. pix_valid never drops mid-frame.
- Counters: x increments on each handshake. At x=IMG_W-1 it wraps to 0 and y increments. Both clear on entering LOAD.
- Flags are combinational from x/y and gated by pix_valid.
- rom_addr width: the final increment after the last word reaches IMG_W*IMG_H and is never read. No wrap occurs within ADDR_W.
- start while busy: ignored; no restart, no error.
- abort (any state except IDLE): next edge -> IDLE. pix_valid=0 the cycle after. No done pulse. Counters and rom_addr cleared.
- abort has priority over start and over the handshake in the same cycle.
- start and abort together in IDLE: abort wins; the block stays IDLE.
- rst_n low mid-frame: immediate return to the reset values. No done pulse. A new start is required.

Decomposition:
- Package img_pkg holds:
  - constants IMG_W, IMG_H, ADDR_W, PIX_W=8, WORD_W=16, FRAME_PIX=IMG_W*IMG_H;
  - typedef pix_t (logic [7:0]);
  - typedef addr_t (logic [ADDR_W-1:0]);
  - enum stream_state_t {IDLE, LOAD, STREAM, DONE}.
- One sub-module, pix_pos_counter: x/y raster counters with enable, clear, and sof/eol/eof decode. Reusable by later window/filter stages.

Test Plan:
- IMG_W=4, IMG_H=2, ROM bytes 0x00..0x07, pix_ready=1, start pulse -> pix_data 00,01,...,07 in cycles 2..9. sof in cycle 2, eol in cycles 5 and 9, eof in cycle 9, done in cycle 10, busy low in cycle 11.
- Same config, pix_ready toggling 1,0,1,0 -> every pixel appears once in order. Stalled cycles hold pix_data and flags unchanged. Exactly 8 handshakes, then done.
- Default 640x480, ROM byte[n]=n[7:0], pix_ready=1 -> 307200 valid cycles with no gaps. Pixel k equals k mod 256. Max rom_addr read is 307198. Single done pulse.
- start re-pulsed mid-frame -> no effect. Output sequence identical to the uninterrupted run.
- abort asserted after the 3rd handshake -> pix_valid=0 next cycle, busy=0, no done. A fresh start streams again from pixel 0 with sof.
- rst_n pulled low mid-frame, asynchronously between edges -> pix_valid, busy and rom_addr go to 0 immediately. After release the block stays idle until start.
